// File: rtl/bnn_cmd_encoder_if.sv
// ---------------------------------------------------------------------------
// bnn_cmd_encoder_if
//
// Bundles the request side and the command byte stream of bnn_cmd_encoder.
//
// Handshake rules for both channels (req_* and cmd_*):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. Once the producer raises valid, it holds valid and the payload
//   stable until that transfer edge. The consumer may raise or lower ready
//   at any time, and ready may be high before valid rises.
//
// Modports:
//   master : the encoder. It consumes req_* and cmd_ready. It drives
//            req_ready, cmd, cmd_valid, done, err, busy and dbg_state.
//   slave  : the environment (host model or testbench), driving the
//            opposite direction.
//
// Signals:
//   req_valid/req_ready  request handshake
//   req_kind  [1:0]      1 inputs, 2 weights, 3 bias (0 illegal)
//   req_len   [3:0]      payload byte count, 1..MAX_LEN
//   req_data             payload, byte i in bits [8i+7:8i]
//   cmd       [7:0]      byte to the decoder (0x00 while cmd_valid is low)
//   cmd_valid/cmd_ready  byte handshake
//   done                 one-cycle pulse after the terminator is accepted
//   err                  one-cycle pulse after an illegal request is dropped
//   busy                 encoder is not idle
//   dbg_state [1:0]      encoder FSM state, for checkers
// ---------------------------------------------------------------------------
interface bnn_cmd_encoder_if #(
    parameter int MAX_LEN = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_kind;
    logic [3:0]             req_len;
    logic [8*MAX_LEN-1:0]   req_data;
    logic [7:0]             cmd;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   done;
    logic                   err;
    logic                   busy;
    logic [1:0]             dbg_state;

    modport master (
        input  req_valid, req_kind, req_len, req_data, cmd_ready,
        output req_ready, cmd, cmd_valid, done, err, busy, dbg_state
    );

    modport slave (
        output req_valid, req_kind, req_len, req_data, cmd_ready,
        input  req_ready, cmd, cmd_valid, done, err, busy, dbg_state
    );
endinterface

// File: rtl/bnn_cmd_encoder.sv
// ---------------------------------------------------------------------------
// bnn_cmd_encoder
//
// Turns one write request into the byte sequence expected by the BNN
// command decoder. The sequence is an opcode byte (0xB0 | kind), then
// req_len payload bytes with byte 0 first, then a 0x00 terminator.
//
// Ports:
//   clk  system clock; all state changes on its rising edge
//   rst  synchronous, active-high reset
//   bus  bnn_cmd_encoder_if.master (request channel, command byte
//        channel, done/err pulses, busy, FSM debug state)
//
// cmd/cmd_valid come straight from flops. The value for the next beat is
// worked out in the same cycle that the current beat transfers. The
// request is copied into local registers when it is accepted, so the host
// may change req_* at any time after that.
// ---------------------------------------------------------------------------
module bnn_cmd_encoder #(
    parameter int MAX_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    bnn_cmd_encoder_if.master         bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OPCODE  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_TERM    = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [1:0]             kind_q, kind_d;
    logic [3:0]             len_q, len_d;
    logic [8*MAX_LEN-1:0]   data_q, data_d;
    logic [3:0]             idx_q, idx_d;
    logic [7:0]             cmd_q, cmd_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   req_legal;
    logic                   xfer;
    logic                   idx_last;

    // Byte select written as a compare loop. This keeps the 4-bit index
    // independent of how many bytes MAX_LEN actually provides.
    function automatic logic [7:0] pick_byte(
        input logic [8*MAX_LEN-1:0] data,
        input logic [3:0]           sel
    );
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (sel == 4'(i)) begin
                b = data[8*i +: 8];
            end
        end
        return b;
    endfunction

    function automatic logic [7:0] opcode_of(input logic [1:0] kind);
        return 8'hB0 | {6'b000000, kind};
    endfunction

    assign req_legal = (bus.req_kind != 2'd0) &&
                       (bus.req_len != 4'd0) &&
                       (bus.req_len <= 4'(MAX_LEN));
    assign xfer      = cmd_valid_q && bus.cmd_ready;
    assign idx_last  = (idx_q == (len_q - 4'd1));

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        len_d       = len_q;
        data_d      = data_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (req_legal) begin
                        kind_d      = bus.req_kind;
                        len_d       = bus.req_len;
                        data_d      = bus.req_data;
                        idx_d       = 4'd0;
                        cmd_d       = opcode_of(bus.req_kind);
                        cmd_valid_d = 1'b1;
                        state_d     = S_OPCODE;
                    end else begin
                        // Illegal requests are still consumed so the host
                        // never stalls on them. Only err reports them.
                        err_d = 1'b1;
                    end
                end
            end

            S_OPCODE: begin
                if (xfer) begin
                    cmd_d   = pick_byte(data_q, idx_q);
                    state_d = S_PAYLOAD;
                end else begin
                    cmd_d = opcode_of(kind_q);
                end
            end

            S_PAYLOAD: begin
                if (xfer) begin
                    if (idx_last) begin
                        cmd_d   = 8'h00;
                        state_d = S_TERM;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cmd_d = pick_byte(data_q, idx_q + 4'd1);
                    end
                end
            end

            S_TERM: begin
                if (xfer) begin
                    cmd_d       = 8'h00;
                    cmd_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                cmd_d       = 8'h00;
                cmd_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= 2'd0;
            len_q       <= 4'd0;
            data_q      <= '0;
            idx_q       <= 4'd0;
            cmd_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            len_q       <= len_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bnn_cmd_encoder.sv
// ---------------------------------------------------------------------------
// tb_bnn_cmd_encoder
//
// Directed bench for bnn_cmd_encoder with MAX_LEN = 4. Inputs change 1 ns
// after the rising edge. A negedge monitor logs every transferred byte
// along with the edge count of the transfer. It also logs done/err pulses
// and whether a stalled byte stays stable. The expected bytes for each
// test go into exp_q, and all results are checked through check().
// ---------------------------------------------------------------------------
module tb_bnn_cmd_encoder;
    localparam int MAX_LEN = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bnn_cmd_encoder_if #(.MAX_LEN(MAX_LEN)) bus ();

    bnn_cmd_encoder #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    int         done_cyc_q[$];
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         stab_err  = 0;
    int         valid_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_cmd   = 8'h00;

    int n_cmp = 0;
    int n_mis = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus.cmd_valid || bus.cmd !== prev_cmd)) stab_err++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                got_q.push_back(bus.cmd);
                got_cyc_q.push_back(cyc);
            end
            if (bus.cmd_valid) valid_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
            end
            if (bus.err) err_cnt++;
            if (bus.done && bus.err) both_cnt++;
            prev_stall = bus.cmd_valid && !bus.cmd_ready;
            prev_cmd   = bus.cmd;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_count"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) check({tag, "_byte"}, got_q[base + i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the edge count of the acceptance edge. After acceptance the
    // payload is inverted so that any late sampling corrupts the stream.
    task automatic send_req(input logic [1:0] k, input logic [3:0] l,
                            input logic [31:0] d, output int acc);
        for (int i = 0; i < 50 && !bus.req_ready; i++) step();
        check("req_ready_wait", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_kind  = k;
        bus.req_len   = l;
        bus.req_data  = d;
        step();
        acc           = cyc;
        bus.req_valid = 1'b0;
        bus.req_data  = ~d;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int start;
        start = done_cnt;
        for (int i = 0; i < maxc && done_cnt == start; i++) step();
        check(tag, done_cnt - start, 1);
    endtask

    task automatic illegal_req(input string tag, input logic [1:0] k, input logic [3:0] l);
        bus.req_valid = 1'b1;
        bus.req_kind  = k;
        bus.req_len   = l;
        bus.req_data  = 32'h12345678;
        step();
        bus.req_valid = 1'b0;
        check({tag, "_err_pulse"}, bus.err, 1);
        check({tag, "_no_valid"}, bus.cmd_valid, 0);
        check({tag, "_idle"}, bus.dbg_state, 0);
        step();
        check({tag, "_err_clear"}, bus.err, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int gbase;
        int dbase;
        int ebase;
        int vbase;
        int bp[7] = '{1, 0, 0, 1, 0, 1, 1};

        bus.req_valid = 1'b0;
        bus.req_kind  = 2'd0;
        bus.req_len   = 4'd0;
        bus.req_data  = '0;
        bus.cmd_ready = 1'b1;

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd", bus.cmd, 8'h00);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_state", bus.dbg_state, 0);
        step();

        // Inputs write, len 1, no backpressure. Upper bytes must not leak.
        gbase = got_q.size();
        dbase = done_cyc_q.size();
        send_req(2'd1, 4'd1, 32'hA5A5A50E, acc);
        check("in_first_valid", bus.cmd_valid, 1);
        check("in_first_cmd", bus.cmd, 8'hB1);
        check("in_req_ready_low", bus.req_ready, 0);
        check("in_busy", bus.busy, 1);
        wait_done("in_done", 20);
        exp_q = '{8'hB1, 8'h0E, 8'h00};
        check_stream("in_stream", gbase);
        if (got_q.size() >= gbase + 3) begin
            check("in_op_cyc", got_cyc_q[gbase], acc);
            check("in_pl_cyc", got_cyc_q[gbase + 1], acc + 1);
            check("in_term_cyc", got_cyc_q[gbase + 2], acc + 2);
        end
        if (done_cyc_q.size() > dbase) check("in_done_cyc", done_cyc_q[dbase], acc + 3);
        check("in_idle_after", bus.req_ready, 1);

        // Weights write, len 2; bytes 2 and 3 must be ignored.
        gbase = got_q.size();
        send_req(2'd2, 4'd2, 32'h7766DE00, acc);
        wait_done("wt_done", 20);
        exp_q = '{8'hB2, 8'h00, 8'hDE, 8'h00};
        check_stream("wt_stream", gbase);

        // Bias write with backpressure pattern 1,0,0,1,0,1,1
        gbase = got_q.size();
        dbase = done_cyc_q.size();
        send_req(2'd3, 4'd2, 32'h0000DE00, acc);
        for (int i = 0; i < 7; i++) begin
            bus.cmd_ready = bp[i][0];
            step();
        end
        bus.cmd_ready = 1'b1;
        wait_done("bp_done", 20);
        exp_q = '{8'hB3, 8'h00, 8'hDE, 8'h00};
        check_stream("bp_stream", gbase);
        if (got_q.size() >= gbase + 4) begin
            check("bp_pl0_cyc", got_cyc_q[gbase + 1], acc + 3);
            check("bp_pl1_cyc", got_cyc_q[gbase + 2], acc + 5);
            check("bp_term_cyc", got_cyc_q[gbase + 3], acc + 6);
        end
        if (done_cyc_q.size() > dbase) check("bp_done_cyc", done_cyc_q[dbase], acc + 7);
        check("bp_stable", stab_err, 0);

        // Illegal requests
        gbase = got_q.size();
        ebase = err_cnt;
        vbase = valid_cnt;
        illegal_req("ill_kind0", 2'd0, 4'd1);
        illegal_req("ill_len0", 2'd1, 4'd0);
        illegal_req("ill_len5", 2'd2, 4'd5);
        check("ill_err_count", err_cnt - ebase, 3);
        check("ill_valid_never", valid_cnt - vbase, 0);
        check("ill_no_bytes", got_q.size() - gbase, 0);
        check("ill_busy", bus.busy, 0);

        // Back-to-back frames with req_valid held high
        gbase = got_q.size();
        dbase = done_cyc_q.size();
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'd1;
        bus.req_len   = 4'd1;
        bus.req_data  = 32'h0000003C;
        step();
        bus.req_kind  = 2'd3;
        bus.req_data  = 32'h0000005A;
        wait_done("b2b_done1", 20);
        bus.req_valid = 1'b0;
        bus.req_data  = 32'hFFFFFFFF;
        wait_done("b2b_done2", 20);
        exp_q = '{8'hB1, 8'h3C, 8'h00, 8'hB3, 8'h5A, 8'h00};
        check_stream("b2b_stream", gbase);
        if (got_q.size() >= gbase + 4 && done_cyc_q.size() > dbase)
            check("b2b_gap", got_cyc_q[gbase + 3], done_cyc_q[dbase] + 1);

        // Reset in the middle of PAYLOAD
        bus.cmd_ready = 1'b1;
        send_req(2'd2, 4'd4, 32'h44332211, acc);
        step();
        check("mid_in_payload", bus.dbg_state, 2);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        gbase = got_q.size();
        ebase = done_cnt;
        check("mid_cmd_valid", bus.cmd_valid, 0);
        check("mid_cmd", bus.cmd, 8'h00);
        check("mid_req_ready", bus.req_ready, 1);
        check("mid_busy", bus.busy, 0);
        repeat (5) step();
        check("mid_no_done", done_cnt - ebase, 0);
        check("mid_no_bytes", got_q.size() - gbase, 0);

        check("done_err_overlap", both_cnt, 0);
        check("stall_stable_all", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
